// File: rtl/genesis_pad_emulator.sv
// genesis_pad_emulator
// Console-facing Genesis / Mega Drive pad responder. It samples the
// console-driven SELECT line, tracks the 6-button select-cycle phase, and
// drives the six active-low data lines from a {Z,Y,X,M,S,C,B,A,U,D,L,R}
// button vector (1 = pressed). The vector layout matches the pad-reader side,
// so a decoded pad can be passed straight through.
//
// SYNC_STAGES must be 2 or 3. TIMEOUT must be at least 2.

module genesis_pad_emulator #(
  parameter int TIMEOUT     = 75000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        iCLK,
  input  logic        iN_RESET,
  input  logic        iSELECT,
  input  logic [11:0] iBUTTONS,
  input  logic        iSIX_BUTTON,
  output logic [5:0]  oGENPAD,
  output logic [2:0]  oPHASE
);

  // Phase encodings for the select-cycle counter.
  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_1     = 3'd1;
  localparam logic [2:0] PH_3     = 3'd3;
  localparam logic [2:0] PH_4     = 3'd4;

  // The timeout counter only has to reach TIMEOUT-1, so this width never wraps.
  localparam int         TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  // Button bit positions inside iBUTTONS.
  localparam int B_R = 0;
  localparam int B_L = 1;
  localparam int B_D = 2;
  localparam int B_U = 3;
  localparam int B_A = 4;
  localparam int B_B = 5;
  localparam int B_C = 6;
  localparam int B_S = 7;
  localparam int B_M = 8;
  localparam int B_X = 9;
  localparam int B_Y = 10;
  localparam int B_Z = 11;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sel_d_q;
  logic                   sel_s;
  logic                   fall;

  logic [2:0]             phase_q,  phase_d;
  logic [TW-1:0]          timer_q,  timer_d;
  logic [5:0]             genpad_q, genpad_d;

  assign sel_s = sync_q[SYNC_STAGES-1];
  assign fall  = sel_d_q & ~sel_s;

  // SELECT synchronizer chain plus the one-cycle delay used for edge detection.
  always_ff @(posedge iCLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would collapse the chain into one flop.
    if (!iN_RESET) begin
      // NOTE: the chain resets to the idle-high SELECT level, so releasing reset
      // while SELECT is high never manufactures a falling edge.
      sync_q  <= '1;
      sel_d_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], iSELECT};
      sel_d_q <= sel_s;
    end
  end

  // Phase counter and idle timeout: a fall advances the phase (saturating at
  // 4) and restarts the timer; a fall that coincides with timer expiry starts
  // a fresh sequence at phase 1; expiry without a fall returns to idle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    phase_d = phase_q;
    timer_d = timer_q;
    if (fall) begin
      timer_d = '0;
      if (timer_q == TIMER_MAX) begin
        phase_d = PH_1;
      end else if (phase_q != PH_4) begin
        phase_d = phase_q + 3'd1;
      end
    end else if (phase_q != PH_IDLE) begin
      if (timer_q == TIMER_MAX) begin
        phase_d = PH_IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TIMER_ONE;
      end
    end else begin
      timer_d = '0;
    end
  end

  // Output mapping from the live SELECT level and the post-update phase, so
  // the word registered on a fall already reflects the new phase.
  always_comb begin
    genpad_d = {~iBUTTONS[B_C], ~iBUTTONS[B_B], ~iBUTTONS[B_U],
                ~iBUTTONS[B_D], ~iBUTTONS[B_L], ~iBUTTONS[B_R]};
    if (!iSIX_BUTTON || (phase_d < PH_3)) begin
      if (!sel_s) begin
        genpad_d = {~iBUTTONS[B_S], ~iBUTTONS[B_A], ~iBUTTONS[B_U],
                    ~iBUTTONS[B_D], 2'b00};
      end
    end else if (phase_d == PH_3) begin
      if (sel_s) begin
        genpad_d = {~iBUTTONS[B_C], ~iBUTTONS[B_B], ~iBUTTONS[B_Z],
                    ~iBUTTONS[B_Y], ~iBUTTONS[B_X], ~iBUTTONS[B_M]};
      end else begin
        genpad_d = {~iBUTTONS[B_S], ~iBUTTONS[B_A], 4'b0000};
      end
    end else begin
      if (!sel_s) begin
        genpad_d = {~iBUTTONS[B_S], ~iBUTTONS[B_A], 4'b1111};
      end
    end
  end

  // Phase, timer and output registers.
  always_ff @(posedge iCLK) begin
    if (!iN_RESET) begin
      phase_q  <= PH_IDLE;
      timer_q  <= '0;
      genpad_q <= 6'b111111;
    end else begin
      phase_q  <= phase_d;
      timer_q  <= timer_d;
      genpad_q <= genpad_d;
    end
  end

  assign oGENPAD = genpad_q;
  assign oPHASE  = phase_q;

endmodule

// File: tb/tb_genesis_pad_emulator.sv
// tb_genesis_pad_emulator
// Directed stimulus with hand-computed expectations. Stimulus tasks push the
// expected {oGENPAD, oPHASE} together with the cycle at which it must appear;
// a negedge monitor pops entries as their cycle arrives and compares.

module tb_genesis_pad_emulator;

  localparam int TIMEOUT = 300;
  localparam int SYNC    = 2;
  localparam int LAT     = SYNC + 1;
  localparam int HALF    = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [11:0] btn;
  logic        six;
  logic [5:0]  gpad;
  logic [2:0]  phase;

  always #10 clk = ~clk;

  genesis_pad_emulator #(
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (SYNC)
  ) dut (
    .iCLK        (clk),
    .iN_RESET    (rst_n),
    .iSELECT     (sel),
    .iBUTTONS    (btn),
    .iSIX_BUTTON (six),
    .oGENPAD     (gpad),
    .oPHASE      (phase)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [5:0] g;
    logic [2:0] p;
  } exp_t;

  exp_t  sb[$];
  string sb_nm[$];
  int    checks   = 0;
  int    failures = 0;

  // 6-button expected words after fall n (low) and the following rise (high),
  // for iBUTTONS = 12'hF00.
  logic [5:0] exp_low  [4] = '{6'b111100, 6'b111100, 6'b110000, 6'b111111};
  logic [5:0] exp_high [4] = '{6'b111111, 6'b111111, 6'b110000, 6'b111111};

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got gpad=%b phase=%0d, want gpad=%b phase=%0d",
               nm, act[8:3], act[2:0], req[8:3], req[2:0]);
    end
  endtask

  task automatic push(input int at, input logic [5:0] g, input logic [2:0] p,
                      input string nm);
    exp_t e;
    e.at = at;
    e.g  = g;
    e.p  = p;
    sb.push_back(e);
    sb_nm.push_back(nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  // Drive SELECT now; the response is due LAT cycles later.
  task automatic sel_step(input logic v, input logic [5:0] g, input logic [2:0] p,
                          input string nm, input int hold);
    int k;
    k   = cyc;
    sel = v;
    push(k + LAT, g, p, nm);
    tick(hold);
  endtask

  // One 4-pulse 6-button burst with iBUTTONS = 12'hF00. Optionally exercises
  // button and mode changes while SELECT is high in phase 3.
  task automatic burst6(input bit extras, output int last_low_k);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) last_low_k = cyc;
      sel_step(1'b0, exp_low[i], 3'(i + 1), "6b_low", HALF);
      sel_step(1'b1, exp_high[i], 3'(i + 1), "6b_high", HALF);
      if (extras && i == 2) begin
        btn = 12'h700;
        push(cyc,     6'b110000, 3'd3, "btn_before");
        push(cyc + 1, 6'b111000, 3'd3, "btn_latency");
        tick(2);
        btn = 12'hF00;
        push(cyc + 1, 6'b110000, 3'd3, "btn_restore");
        tick(2);
        six = 1'b0;
        push(cyc + 1, 6'b111111, 3'd3, "six_off_mid");
        tick(2);
        six = 1'b1;
        push(cyc + 1, 6'b110000, 3'd3, "six_on_mid");
        tick(2);
      end
    end
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t  e;
      string nm;
      e  = sb.pop_front();
      nm = sb_nm.pop_front();
      if (e.at < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", nm, e.at, cyc);
      end else begin
        check(nm, {gpad, phase}, {e.g, e.p});
      end
    end
  end

  initial begin
    int kl;
    int f;
    int k2;

    rst_n = 1'b0;
    sel   = 1'b1;
    btn   = 12'h000;
    six   = 1'b0;
    tick(3);
    push(cyc, 6'b111111, 3'd0, "reset_hold");
    tick(1);
    rst_n = 1'b1;
    push(cyc + 2, 6'b111111, 3'd0, "idle_after_reset");
    tick(4);

    // 3-button pad, S,C,B,A pressed.
    btn = 12'h0F0;
    push(cyc,     6'b111111, 3'd0, "3b_btn_before");
    push(cyc + 1, 6'b001111, 3'd0, "3b_btn_latency");
    tick(4);
    kl = cyc;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) kl = cyc;
      sel_step(1'b0, 6'b001100, 3'((i > 4) ? 4 : i), "3b_low", HALF);
      sel_step(1'b1, 6'b001111, 3'((i > 4) ? 4 : i), "3b_high", HALF);
    end
    f = kl + LAT;
    push(f + TIMEOUT - 1, 6'b001111, 3'd4, "3b_pre_timeout");
    push(f + TIMEOUT,     6'b001111, 3'd0, "3b_timeout");
    wait_until(f + TIMEOUT + 2);

    // 6-button pad, Z,Y,X,M pressed.
    six = 1'b1;
    btn = 12'hF00;
    push(cyc + 1, 6'b111111, 3'd0, "6b_idle");
    tick(4);
    push(cyc + LAT - 1, 6'b111111, 3'd0, "sel_latency_early");
    burst6(1'b1, kl);
    f = kl + LAT;
    push(f + TIMEOUT - 1, 6'b111111, 3'd4, "6b_pre_timeout");
    push(f + TIMEOUT,     6'b111111, 3'd0, "6b_timeout");
    wait_until(f + TIMEOUT + 2);

    // Fresh burst after timeout: phase-3 high shows XYZM again.
    burst6(1'b0, kl);

    // Gap of TIMEOUT-2 between falls: phase stays saturated.
    wait_until(kl + TIMEOUT - 2);
    k2 = cyc;
    sel_step(1'b0, 6'b111111, 3'd4, "gap_short_low", HALF);
    sel_step(1'b1, 6'b111111, 3'd4, "gap_short_high", HALF);

    // Fall coinciding with timer expiry starts a new sequence at phase 1.
    push(k2 + LAT + TIMEOUT - 1, 6'b111111, 3'd4, "edge_pre_expiry");
    wait_until(k2 + TIMEOUT);
    sel_step(1'b0, 6'b111100, 3'd1, "edge_coincide", HALF);

    // Advance to phase 3 high, then pulse reset.
    sel_step(1'b1, 6'b111111, 3'd1, "seq_high1", HALF);
    sel_step(1'b0, 6'b111100, 3'd2, "seq_low2",  HALF);
    sel_step(1'b1, 6'b111111, 3'd2, "seq_high2", HALF);
    sel_step(1'b0, 6'b110000, 3'd3, "seq_low3",  HALF);
    sel_step(1'b1, 6'b110000, 3'd3, "seq_high3", HALF);
    rst_n = 1'b0;
    push(cyc + 1, 6'b111111, 3'd0, "reset_mid_phase3");
    tick(1);
    rst_n = 1'b1;
    push(cyc + 1, 6'b111111, 3'd0, "reset_mid_release");
    tick(HALF);
    sel_step(1'b0, 6'b111100, 3'd1, "post_reset_fall", HALF);
    sel_step(1'b1, 6'b111111, 3'd1, "post_reset_rise", HALF);

    for (int i = 0; i < 200 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations never reached, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
